// File: rtl/gate_array_regs.sv
// Gate array register file: decodes Z80 I/O writes and holds the pen, ink, border,
// mode, ROM and RAM configuration. It also provides the interrupt acknowledge and clear pulses.
`timescale 1ns/1ps
module gate_array_regs #(
    parameter logic [4:0] INK_RESET  = 5'd20,
    parameter logic [1:0] MODE_RESET = 2'd1,
    parameter bit         MODE_SYNC  = 1'b1
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data,
    input  logic       n_iorq,
    input  logic       n_wr,
    input  logic       n_m1,
    input  logic       hsync_n,
    input  logic [3:0] pen,
    output logic [4:0] color,
    output logic [4:0] border_color,
    output logic [1:0] mode,
    output logic       lower_rom_dis,
    output logic       upper_rom_dis,
    output logic [2:0] ram_config,
    output logic       int_ack,
    output logic       int_clear
);

    typedef enum logic [1:0] {
        FN_SELECT = 2'b00,
        FN_INK    = 2'b01,
        FN_CONFIG = 2'b10,
        FN_RAM    = 2'b11
    } func_e;

    logic [4:0] ink_q [16];
    logic [4:0] ink_d [16];
    logic [4:0] border_q, border_d;
    logic [3:0] pen_sel_q, pen_sel_d;
    logic       border_sel_q, border_sel_d;
    logic [1:0] pending_q, pending_d;
    logic [1:0] mode_q, mode_d;
    logic       lrom_q, lrom_d;
    logic       urom_q, urom_d;
    logic [2:0] ram_q, ram_d;
    logic       armed_q, armed_d;
    logic       ack_armed_q, ack_armed_d;
    logic       int_clear_q, int_clear_d;
    logic       hsync_q, hsync_d;

    logic       wr_cond, strobe, ack_cond, hsync_fall;
    func_e      func;
    logic       unused_addr;

    assign unused_addr = ^cpu_addr[5:0];

    always_comb begin
        wr_cond    = !n_iorq && !n_wr && n_m1 && !cpu_addr[7] && cpu_addr[6];
        strobe     = wr_cond && armed_q;
        ack_cond   = !n_m1 && !n_iorq;
        func       = func_e'(cpu_data[7:6]);
        // Edge is registered previous level against the live input.
        hsync_fall = hsync_q && !hsync_n;

        ink_d        = ink_q;
        border_d     = border_q;
        pen_sel_d    = pen_sel_q;
        border_sel_d = border_sel_q;
        pending_d    = pending_q;
        lrom_d       = lrom_q;
        urom_d       = urom_q;
        ram_d        = ram_q;
        int_clear_d  = 1'b0;
        armed_d      = !wr_cond;
        ack_armed_d  = !ack_cond;
        hsync_d      = hsync_n;

        if (strobe) begin
            case (func)
                FN_SELECT: begin
                    border_sel_d = cpu_data[4];
                    pen_sel_d    = cpu_data[3:0];
                end
                FN_INK: begin
                    if (border_sel_q) border_d = cpu_data[4:0];
                    else              ink_d[pen_sel_q] = cpu_data[4:0];
                end
                FN_CONFIG: begin
                    pending_d   = cpu_data[1:0];
                    lrom_d      = cpu_data[2];
                    urom_d      = cpu_data[3];
                    int_clear_d = cpu_data[4];
                end
                FN_RAM: ram_d = cpu_data[2:0];
                default: ;
            endcase
        end

        // Mode samples the old pending value, so a same-cycle config write waits.
        mode_d = mode_q;
        if (MODE_SYNC) begin
            if (hsync_fall) mode_d = pending_q;
        end else begin
            mode_d = pending_q;
        end

        int_ack       = ack_cond && ack_armed_q;
        color         = ink_q[pen];
        border_color  = border_q;
        mode          = mode_q;
        lower_rom_dis = lrom_q;
        upper_rom_dis = urom_q;
        ram_config    = ram_q;
        int_clear     = int_clear_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ink_q        <= '{default: INK_RESET};
            border_q     <= INK_RESET;
            pen_sel_q    <= '0;
            border_sel_q <= 1'b0;
            pending_q    <= MODE_RESET;
            mode_q       <= MODE_RESET;
            lrom_q       <= 1'b0;
            urom_q       <= 1'b0;
            ram_q        <= '0;
            armed_q      <= 1'b1;
            ack_armed_q  <= 1'b1;
            int_clear_q  <= 1'b0;
            hsync_q      <= 1'b1;
        end else begin
            ink_q        <= ink_d;
            border_q     <= border_d;
            pen_sel_q    <= pen_sel_d;
            border_sel_q <= border_sel_d;
            pending_q    <= pending_d;
            mode_q       <= mode_d;
            lrom_q       <= lrom_d;
            urom_q       <= urom_d;
            ram_q        <= ram_d;
            armed_q      <= armed_d;
            ack_armed_q  <= ack_armed_d;
            int_clear_q  <= int_clear_d;
            hsync_q      <= hsync_d;
        end
    end

endmodule

// File: doc/gate_array_regs.md
Name: gate_array_regs

Overview:
CPU-facing register side of the video path. It decodes Z80 I/O writes to the gate array (A15=0, A14=1) and holds the pen-select, ink palette, border, screen-mode, ROM-enable and RAM-config registers. The video scanout block sends it a pen index and gets back a colour index. It also supplies the video block's mode, border colour, interrupt-acknowledge and interrupt-clear inputs.

Parameters:
INK_RESET, 20, reset colour index for all 16 inks and the border (20 = black)
MODE_RESET, 1, screen mode after reset
MODE_SYNC, 1, 1: a mode write takes effect at the next hsync start; 0: it takes effect the cycle after the write

Ports:
clk  input  1  system clock; all logic is on the rising edge
n_reset  input  1  asynchronous active-low reset
cpu_addr  input  8  CPU address bits 15:8
cpu_data  input  8  CPU write data
n_iorq  input  1  Z80 IORQ, active low, synchronous to clk
n_wr  input  1  Z80 WR, active low
n_m1  input  1  Z80 M1, active low
hsync_n  input  1  horizontal sync from the video block, active low
pen  input  4  pen index from the video block
color  output  5  ink colour index for pen (combinational)
border_color  output  5  border colour index
mode  output  2  screen mode currently applied
lower_rom_dis  output  1  lower ROM disable
upper_rom_dis  output  1  upper ROM disable
ram_config  output  3  RAM banking configuration
int_ack  output  1  one-cycle pulse on interrupt acknowledge
int_clear  output  1  one-cycle pulse on an interrupt-delay reset write

Behaviour:
- Reset is asynchronous (n_reset low). Reset values:
  - all inks = INK_RESET; border = INK_RESET
  - pen_sel = 0; border_sel = 0
  - mode and pending mode = MODE_RESET
  - lower_rom_dis = 0; upper_rom_dis = 0; ram_config = 0
  - int_ack = 0; int_clear = 0
- Write condition: n_iorq=0, n_wr=0, n_m1=1, cpu_addr[7]=0, cpu_addr[6]=1.
- Write strobe: one-cycle strobe on the first cycle the write condition is true.
  - A registered "armed" flag is set at reset. It re-arms only after a cycle in which the condition is false.
  - A write held for N cycles therefore performs exactly one update.
- Register updates land on the strobe edge and are visible the next cycle. Function is selected by cpu_data[7:6]:
  - 00 (select): border_sel <= data[4]; pen_sel <= data[3:0].
  - 01 (ink): if border_sel, border <= data[4:0]; otherwise ink[pen_sel] <= data[4:0].
  - 10 (config):
    - pending_mode <= data[1:0]
    - lower_rom_dis <= data[2]; upper_rom_dis <= data[3]
    - if data[4]=1, int_clear pulses high for exactly one cycle, the cycle after the strobe
  - 11 (RAM): ram_config <= data[2:0].
- Mode application:
  - MODE_SYNC=1: hsync_n is registered. On the cycle its falling edge is detected (prev=1, now=0), mode <= pending_mode.
  - A config write on the same cycle as the edge is not applied at that edge. It is applied at the following hsync.
  - MODE_SYNC=0: mode follows pending_mode one cycle later.
- Interrupt acknowledge:
  - Acknowledge condition: n_m1=0 and n_iorq=0.
  - int_ack is a one-cycle pulse on the first cycle of the condition.
  - It re-arms after a cycle in which the condition is false, so a held cycle gives one pulse.
  - The acknowledge cycle never counts as a write, because the write condition requires n_m1=1.
- Colour lookup: color = ink[pen], combinational, zero latency. border_color is the register output.
- A write to ink[pen_sel] while pen == pen_sel: color changes the cycle after the strobe. No glitch beyond that single transition.
- Reset asserted mid-write: every register returns to its reset value. armed = 1, so a write still held when n_reset rises is strobed once.
- Any other address in 0x00–0xFF of cpu_addr, such as 0xBF, 0x3F or 0xFF, is ignored.

Test Plan:
- Reset: pulse n_reset low with no clock edge.
  - Outputs: mode=1, border_color=20, color=20 for pen 0..15, all pulses 0, rom_dis=0, ram_config=0.
- Ink write:
  - Write 0x7F00 data 0x03, then data 0x4B.
  - pen=3 gives color=11; pen=2 gives color=20; border_color=20.
- Border and held write:
  - Write data 0x10, then data 0x4C held for 8 cycles.
  - border_color=12; inks unchanged.
  - Data 0x4C is accepted once: change the bus data to 0x45 while still held and border stays 12.
  - A write to address 0xBF is ignored.
- Mode sync:
  - Write data 0x8E with hsync_n high: lower_rom_dis=1 and upper_rom_dis=1 next cycle; mode stays 1.
  - Drive hsync_n low: mode=2 one cycle after the edge is detected.
  - Write 0x9C: int_clear high for exactly one cycle; pending mode=0.
- Interrupt ack: hold n_m1=0 and n_iorq=0 for 4 cycles.
  - int_ack is 1 for exactly one cycle.
  - No register changes, even with n_wr=0 and cpu_addr=0x7F.
- RAM and reset mid-write:
  - Write data 0xC5: ram_config=5.
  - Assert n_reset low during a held write 0x4F: ink[0]=20.
  - Release reset with the write still held: ink[0]=15 after one strobe.
